// File: rtl/sync_meas_pkg.sv
// Shared types and constants for the sync measurement block.
package sync_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  localparam int unsigned HTW_W = 12;
  localparam int unsigned VTW_W = 11;
  localparam int unsigned SUM_W = 32;
  localparam int unsigned PIX_W = 8;

  localparam logic [PIX_W-1:0] MIN_INIT = '1;
  localparam logic [PIX_W-1:0] MAX_INIT = '0;

endpackage

// File: rtl/sync_meas_lock.sv
// Timing-stability tracker: counts consecutive published frames whose
// HTW/VTW/HW/VW match the previously published frame.
module sync_meas_lock
  import sync_meas_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic             PCK,
  input  logic             RSTN,
  input  logic             clr,
  input  logic             pub,
  input  logic [HTW_W-1:0] htw,
  input  logic [VTW_W-1:0] vtw,
  input  logic [HTW_W-1:0] hw,
  input  logic [VTW_W-1:0] vw,
  output logic             lock
);

  localparam int unsigned CW = $clog2(LOCK_CNT + 1);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             have_prev;
  logic             same;
  logic [HTW_W-1:0] prev_htw;
  logic [VTW_W-1:0] prev_vtw;
  logic [HTW_W-1:0] prev_hw;
  logic [VTW_W-1:0] prev_vw;

  // Next lock count: reload to 1 on any change or first frame, else saturating increment
  always_comb begin
    same    = have_prev && (htw == prev_htw) && (vtw == prev_vtw) &&
              (hw == prev_hw) && (vw == prev_vw);
    cnt_nxt = CW'(1);
    if (same) begin
      cnt_nxt = (cnt >= CW'(LOCK_CNT)) ? cnt : cnt + CW'(1);
    end
  end

  // Counter, previous-frame snapshot and lock flag, all updated with the publish strobe
  always_ff @(posedge PCK or negedge RSTN) begin
    if (!RSTN) begin
      cnt       <= '0;
      have_prev <= 1'b0;
      lock      <= 1'b0;
      prev_htw  <= '0;
      prev_vtw  <= '0;
      prev_hw   <= '0;
      prev_vw   <= '0;
    end else if (clr) begin
      cnt       <= '0;
      have_prev <= 1'b0;
      lock      <= 1'b0;
    end else if (pub) begin
      cnt       <= cnt_nxt;
      have_prev <= 1'b1;
      lock      <= (cnt_nxt >= CW'(LOCK_CNT));
      prev_htw  <= htw;
      prev_vtw  <= vtw;
      prev_hw   <= hw;
      prev_vw   <= vw;
    end
  end

endmodule

// File: rtl/sync_meas.sv
// Video timing and active-pixel statistics measurement with lock and
// loss-of-sync detection.
module sync_meas
  import sync_meas_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned TO_CYC   = 4096
) (
  input  logic             PCK,
  input  logic             RSTN,
  input  logic             HLOCK,
  input  logic             VLOCK,
  input  logic             ACT,
  input  logic [9:0]       DI,
  input  logic             EN,
  output logic [HTW_W-1:0] MEAS_HTW,
  output logic [VTW_W-1:0] MEAS_VTW,
  output logic [HTW_W-1:0] MEAS_HW,
  output logic [VTW_W-1:0] MEAS_VW,
  output logic [SUM_W-1:0] MEAS_SUM,
  output logic [PIX_W-1:0] MEAS_MIN,
  output logic [PIX_W-1:0] MEAS_MAX,
  output logic             MEAS_VALID,
  output logic             MEAS_LOCK,
  output logic             MEAS_TO
);

  localparam int unsigned TOW = $clog2(TO_CYC + 1);

  state_t           state;

  logic [HTW_W-1:0] hcnt;
  logic [VTW_W-1:0] vcnt;
  logic [HTW_W-1:0] hact;
  logic [HTW_W-1:0] hw_acc;
  logic [VTW_W-1:0] vw_acc;
  logic [SUM_W-1:0] sum_acc;
  logic [PIX_W-1:0] min_acc;
  logic [PIX_W-1:0] max_acc;
  logic [TOW-1:0]   tocnt;

  logic             hl;
  logic             run;
  logic             timeout;
  logic             pub;
  logic [PIX_W-1:0] pix;
  logic [HTW_W-1:0] line_len;
  logic [VTW_W-1:0] frame_vtw;
  logic [HTW_W-1:0] line_act;
  logic [HTW_W-1:0] frame_hw;
  logic [VTW_W-1:0] frame_vw;
  logic [SUM_W:0]   sum_add;
  logic [SUM_W-1:0] frame_sum;
  logic [PIX_W-1:0] frame_min;
  logic [PIX_W-1:0] frame_max;
  logic             unused_di;

  assign unused_di = ^DI[1:0];

  // Current-cycle view of line/frame totals, including this cycle's pixel and sync pulse
  always_comb begin
    hl        = HLOCK | VLOCK;
    run       = EN && (state != ST_IDLE);
    pix       = DI[9:2];
    timeout   = run && !hl && (tocnt == TOW'(TO_CYC - 1));
    pub       = EN && (state == ST_MEAS) && VLOCK;
    line_len  = (hcnt == '1) ? hcnt : hcnt + HTW_W'(1);
    frame_vtw = (vcnt == '1) ? vcnt : vcnt + VTW_W'(1);
    line_act  = hact;
    if (ACT && (hact != '1)) begin
      line_act = hact + HTW_W'(1);
    end
    frame_hw  = hw_acc;
    frame_vw  = vw_acc;
    if (line_act != '0) begin
      frame_hw = line_act;
      frame_vw = (vw_acc == '1) ? vw_acc : vw_acc + VTW_W'(1);
    end
    sum_add   = {1'b0, sum_acc} + {{(SUM_W - PIX_W + 1){1'b0}}, pix};
    frame_sum = sum_acc;
    frame_min = min_acc;
    frame_max = max_acc;
    if (ACT) begin
      frame_sum = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
      if (pix < min_acc) frame_min = pix;
      if (pix > max_acc) frame_max = pix;
    end
  end

  // Line/frame accumulators and the no-HLOCK watchdog; held cleared while not running
  always_ff @(posedge PCK or negedge RSTN) begin
    if (!RSTN) begin
      hcnt    <= '0;
      vcnt    <= '0;
      hact    <= '0;
      hw_acc  <= '0;
      vw_acc  <= '0;
      sum_acc <= '0;
      min_acc <= MIN_INIT;
      max_acc <= MAX_INIT;
      tocnt   <= '0;
    end else if (!run) begin
      hcnt    <= '0;
      vcnt    <= '0;
      hact    <= '0;
      hw_acc  <= '0;
      vw_acc  <= '0;
      sum_acc <= '0;
      min_acc <= MIN_INIT;
      max_acc <= MAX_INIT;
      tocnt   <= '0;
    end else begin
      tocnt <= (hl || timeout) ? '0 : tocnt + TOW'(1);
      if (VLOCK) begin
        hcnt    <= '0;
        vcnt    <= '0;
        hact    <= '0;
        hw_acc  <= '0;
        vw_acc  <= '0;
        sum_acc <= '0;
        min_acc <= MIN_INIT;
        max_acc <= MAX_INIT;
      end else begin
        sum_acc <= frame_sum;
        min_acc <= frame_min;
        max_acc <= frame_max;
        if (HLOCK) begin
          hcnt   <= '0;
          vcnt   <= frame_vtw;
          hact   <= '0;
          hw_acc <= frame_hw;
          vw_acc <= frame_vw;
        end else begin
          hcnt <= line_len;
          hact <= line_act;
        end
      end
    end
  end

  // Control FSM with registered publish strobe, timeout flag and measurement outputs
  always_ff @(posedge PCK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= ST_IDLE;
      MEAS_VALID <= 1'b0;
      MEAS_TO    <= 1'b0;
      MEAS_HTW   <= '0;
      MEAS_VTW   <= '0;
      MEAS_HW    <= '0;
      MEAS_VW    <= '0;
      MEAS_SUM   <= '0;
      MEAS_MIN   <= MIN_INIT;
      MEAS_MAX   <= MAX_INIT;
    end else begin
      MEAS_VALID <= pub;
      if (!EN) begin
        state   <= ST_IDLE;
        MEAS_TO <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_SEEK;
          ST_SEEK: begin
            if (timeout) MEAS_TO <= 1'b1;
            else if (VLOCK) state <= ST_MEAS;
          end
          ST_MEAS: begin
            if (timeout) begin
              MEAS_TO <= 1'b1;
              state   <= ST_SEEK;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
      if (pub) begin
        MEAS_HTW <= line_len;
        MEAS_VTW <= frame_vtw;
        MEAS_HW  <= frame_hw;
        MEAS_VW  <= frame_vw;
        MEAS_SUM <= frame_sum;
        MEAS_MIN <= frame_min;
        MEAS_MAX <= frame_max;
      end
    end
  end

  sync_meas_lock #(
    .LOCK_CNT(LOCK_CNT)
  ) u_lock (
    .PCK  (PCK),
    .RSTN (RSTN),
    .clr  (!EN || timeout),
    .pub  (pub),
    .htw  (line_len),
    .vtw  (frame_vtw),
    .hw   (frame_hw),
    .vw   (frame_vw),
    .lock (MEAS_LOCK)
  );

endmodule

// File: tb/tb_sync_meas.sv
// Scoreboard bench for sync_meas: frame stimulus pushes expected publishes,
// a negedge monitor pops and compares them on MEAS_VALID.
module tb_sync_meas;

  localparam int unsigned LOCK_CNT = 3;
  localparam int unsigned TO_CYC   = 4096;

  logic        PCK = 1'b0;
  logic        RSTN = 1'b0;
  logic        HLOCK = 1'b0;
  logic        VLOCK = 1'b0;
  logic        ACT = 1'b0;
  logic [9:0]  DI = '0;
  logic        EN = 1'b0;
  logic [11:0] MEAS_HTW;
  logic [10:0] MEAS_VTW;
  logic [11:0] MEAS_HW;
  logic [10:0] MEAS_VW;
  logic [31:0] MEAS_SUM;
  logic [7:0]  MEAS_MIN;
  logic [7:0]  MEAS_MAX;
  logic        MEAS_VALID;
  logic        MEAS_LOCK;
  logic        MEAS_TO;

  sync_meas #(
    .LOCK_CNT(LOCK_CNT),
    .TO_CYC  (TO_CYC)
  ) dut (
    .PCK       (PCK),
    .RSTN      (RSTN),
    .HLOCK     (HLOCK),
    .VLOCK     (VLOCK),
    .ACT       (ACT),
    .DI        (DI),
    .EN        (EN),
    .MEAS_HTW  (MEAS_HTW),
    .MEAS_VTW  (MEAS_VTW),
    .MEAS_HW   (MEAS_HW),
    .MEAS_VW   (MEAS_VW),
    .MEAS_SUM  (MEAS_SUM),
    .MEAS_MIN  (MEAS_MIN),
    .MEAS_MAX  (MEAS_MAX),
    .MEAS_VALID(MEAS_VALID),
    .MEAS_LOCK (MEAS_LOCK),
    .MEAS_TO   (MEAS_TO)
  );

  always #5 PCK = ~PCK;

  typedef struct {
    int     htw;
    int     vtw;
    int     hw;
    int     vw;
    longint sum;
    int     mn;
    int     mx;
    bit     lock;
  } exp_t;

  exp_t sbq[$];
  exp_t last_pub;
  exp_t m_prev;
  int   m_cnt = 0;
  bit   m_have = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Scoreboard monitor: every publish must match the oldest expected frame
  always @(negedge PCK) begin
    exp_t e;
    if (RSTN && MEAS_VALID) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid got MEAS_VALID=1 want no publish (t=%0t)", $time);
      end else begin
        e = sbq.pop_front();
        if (MEAS_HTW !== 12'(e.htw) || MEAS_VTW !== 11'(e.vtw) ||
            MEAS_HW !== 12'(e.hw) || MEAS_VW !== 11'(e.vw) ||
            MEAS_SUM !== 32'(e.sum) || MEAS_MIN !== 8'(e.mn) ||
            MEAS_MAX !== 8'(e.mx) || MEAS_LOCK !== e.lock) begin
          failures++;
          $display("FAIL publish got htw=%0d vtw=%0d hw=%0d vw=%0d sum=%0d min=%0d max=%0d lock=%0b want htw=%0d vtw=%0d hw=%0d vw=%0d sum=%0d min=%0d max=%0d lock=%0b",
                   MEAS_HTW, MEAS_VTW, MEAS_HW, MEAS_VW, MEAS_SUM, MEAS_MIN, MEAS_MAX, MEAS_LOCK,
                   e.htw, e.vtw, e.hw, e.vw, e.sum, e.mn, e.mx, e.lock);
        end
      end
    end
  end

  task automatic drive_cycle(input logic hl, input logic vl, input logic act, input logic [9:0] d);
    HLOCK = hl;
    VLOCK = vl;
    ACT   = act;
    DI    = d;
    @(posedge PCK);
    #1;
  endtask

  task automatic model_clear();
    m_cnt  = 0;
    m_have = 1'b0;
  endtask

  // One full frame; active window cols c0..c1, rows r0..r1; pub = frame should be published
  task automatic drive_frame(input int h, input int v, input int c0, input int c1,
                             input int r0, input int r1, input bit ramp, input bit pub);
    exp_t       e;
    int         k;
    int         val;
    int         lact;
    bit         a;
    logic [9:0] d;
    e.htw = h; e.vtw = v; e.hw = 0; e.vw = 0;
    e.sum = 0; e.mn = 255; e.mx = 0; e.lock = 1'b0;
    k = 0;
    for (int r = 0; r < v; r++) begin
      lact = 0;
      for (int c = 0; c < h; c++) begin
        a = (c >= c0) && (c <= c1) && (r >= r0) && (r <= r1);
        if (a) begin
          val = ramp ? 1 + (k % 255) : 128;
          d   = ramp ? 10'((val << 2) | (k & 3)) : 10'h200;
          lact++;
          k++;
          e.sum += val;
          if (val < e.mn) e.mn = val;
          if (val > e.mx) e.mx = val;
        end else begin
          d = 10'h3FF;
        end
        drive_cycle(c == h - 1, (c == h - 1) && (r == v - 1), a, d);
      end
      if (lact > 0) begin
        e.hw = lact;
        e.vw++;
      end
    end
    HLOCK = 1'b0; VLOCK = 1'b0; ACT = 1'b0;
    if (pub) begin
      if (m_have && e.htw == m_prev.htw && e.vtw == m_prev.vtw &&
          e.hw == m_prev.hw && e.vw == m_prev.vw) begin
        if (m_cnt < int'(LOCK_CNT)) m_cnt++;
      end else begin
        m_cnt = 1;
      end
      m_have = 1'b1;
      m_prev = e;
      e.lock = (m_cnt >= int'(LOCK_CNT));
      last_pub = e;
      sbq.push_back(e);
    end
  endtask

  // Partial frame: n lines with HLOCK only, bright active pixels
  task automatic drive_lines(input int h, input int n);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < h; c++) begin
        drive_cycle(c == h - 1, 1'b0, (c >= 2) && (c <= 5), 10'h3FC);
      end
    end
    HLOCK = 1'b0; ACT = 1'b0;
  endtask

  task automatic test_reset();
    logic [98:0] got;
    logic [98:0] want;
    RSTN = 1'b0;
    EN   = 1'b0;
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, '0);
    got  = {MEAS_HTW, MEAS_VTW, MEAS_HW, MEAS_VW, MEAS_SUM, MEAS_MIN, MEAS_MAX,
            MEAS_VALID, MEAS_LOCK, MEAS_TO};
    want = {12'd0, 11'd0, 12'd0, 11'd0, 32'd0, 8'hFF, 8'h00, 3'b000};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_values got %h want %h", got, want);
    end
    RSTN = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_basic_lock();
    EN = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    drive_frame(20, 10, 2, 13, 2, 7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_frame(20, 10, 2, 13, 2, 7, 1'b0, 1'b1);
    checks++;
    if (MEAS_LOCK !== 1'b1) begin
      failures++;
      $display("FAIL lock_after_4th got %0b want 1", MEAS_LOCK);
    end
    for (int i = 0; i < 3; i++) drive_frame(21, 10, 2, 13, 2, 7, 1'b0, 1'b1);
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL basic_pending got %0d want 0", sbq.size());
    end
  endtask

  task automatic test_ramp_and_empty();
    drive_frame(40, 12, 2, 39, 2, 11, 1'b1, 1'b1);
    drive_frame(20, 10, 1, 0, 0, -1, 1'b0, 1'b1);
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL ramp_pending got %0d want 0", sbq.size());
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 3; i++) drive_frame(20, 10, 2, 13, 2, 7, 1'b0, 1'b1);
    checks++;
    if (MEAS_LOCK !== 1'b1) begin
      failures++;
      $display("FAIL lock_before_to got %0b want 1", MEAS_LOCK);
    end
    repeat (TO_CYC - 1) drive_cycle(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (MEAS_TO !== 1'b0) begin
      failures++;
      $display("FAIL to_early got %0b want 0", MEAS_TO);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (MEAS_TO !== 1'b1 || MEAS_LOCK !== 1'b0) begin
      failures++;
      $display("FAIL to_set got to=%0b lock=%0b want to=1 lock=0", MEAS_TO, MEAS_LOCK);
    end
    model_clear();
    drive_frame(20, 10, 2, 13, 2, 7, 1'b0, 1'b0);
    drive_frame(20, 10, 2, 13, 2, 7, 1'b0, 1'b1);
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (MEAS_TO !== 1'b1 || sbq.size() != 0) begin
      failures++;
      $display("FAIL to_resume got to=%0b pending=%0d want to=1 pending=0", MEAS_TO, sbq.size());
    end
  endtask

  task automatic test_en_drop();
    for (int i = 0; i < 2; i++) drive_frame(20, 10, 2, 13, 2, 7, 1'b0, 1'b1);
    checks++;
    if (MEAS_LOCK !== 1'b1) begin
      failures++;
      $display("FAIL lock_before_en got %0b want 1", MEAS_LOCK);
    end
    drive_lines(20, 3);
    EN = 1'b0;
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, '0);
    drive_frame(20, 10, 2, 13, 2, 7, 1'b0, 1'b0);
    checks++;
    if (MEAS_HTW !== 12'(last_pub.htw) || MEAS_VTW !== 11'(last_pub.vtw) ||
        MEAS_HW !== 12'(last_pub.hw) || MEAS_VW !== 11'(last_pub.vw) ||
        MEAS_SUM !== 32'(last_pub.sum) || MEAS_MIN !== 8'(last_pub.mn) ||
        MEAS_MAX !== 8'(last_pub.mx) || MEAS_LOCK !== 1'b0 || MEAS_TO !== 1'b0) begin
      failures++;
      $display("FAIL en_hold got htw=%0d vtw=%0d hw=%0d vw=%0d sum=%0d min=%0d max=%0d lock=%0b to=%0b want htw=%0d vtw=%0d hw=%0d vw=%0d sum=%0d min=%0d max=%0d lock=0 to=0",
               MEAS_HTW, MEAS_VTW, MEAS_HW, MEAS_VW, MEAS_SUM, MEAS_MIN, MEAS_MAX, MEAS_LOCK, MEAS_TO,
               last_pub.htw, last_pub.vtw, last_pub.hw, last_pub.vw, last_pub.sum, last_pub.mn, last_pub.mx);
    end
    model_clear();
    EN = 1'b1;
    drive_frame(20, 10, 2, 13, 2, 7, 1'b0, 1'b0);
    drive_frame(20, 10, 2, 13, 2, 7, 1'b0, 1'b1);
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL en_pending got %0d want 0", sbq.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [98:0] got;
    logic [98:0] want;
    drive_frame(20, 10, 2, 13, 2, 7, 1'b0, 1'b1);
    drive_lines(20, 4);
    RSTN = 1'b0;
    #2;
    got  = {MEAS_HTW, MEAS_VTW, MEAS_HW, MEAS_VW, MEAS_SUM, MEAS_MIN, MEAS_MAX,
            MEAS_VALID, MEAS_LOCK, MEAS_TO};
    want = {12'd0, 11'd0, 12'd0, 11'd0, 32'd0, 8'hFF, 8'h00, 3'b000};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_mid got %h want %h", got, want);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    RSTN = 1'b1;
    model_clear();
    drive_frame(20, 10, 2, 13, 2, 7, 1'b0, 1'b0);
    drive_frame(20, 10, 2, 13, 2, 7, 1'b0, 1'b1);
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL reset_pending got %0d want 0", sbq.size());
    end
  endtask

  initial begin
    @(posedge PCK);
    #1;
    test_reset();
    test_basic_lock();
    test_ramp_and_empty();
    test_timeout();
    test_en_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_meas.md
SYNC_MEAS -- requirements
Module: sync_meas

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 3: consecutive identical published frames required for lock.
REQ-002 SHALL have parameter TO_CYC, default 4096: PCK cycles without HLOCK that count as loss of sync.
REQ-003 SHALL have port PCK  in  1  pixel clock; all logic on rising edge.
REQ-004 SHALL have port RSTN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port HLOCK  in  1  one-cycle end-of-line pulse from the sync generator.
REQ-006 SHALL have port VLOCK  in  1  one-cycle end-of-frame pulse, coincident with the last HLOCK.
REQ-007 SHALL have port ACT  in  1  active-pixel qualifier.
REQ-008 SHALL have port DI  in  10  pixel data; DI[9:2] is the 8-bit sample.
REQ-009 SHALL have port EN  in  1  measurement enable.
REQ-010 SHALL have outputs MEAS_HTW (12), MEAS_VTW (11), MEAS_HW (12) and MEAS_VW (11): the measured timing.
REQ-011 SHALL have outputs MEAS_SUM (32), MEAS_MIN (8) and MEAS_MAX (8): the active-pixel statistics.
REQ-012 SHALL have outputs MEAS_VALID (1), a one-cycle publish strobe, and MEAS_LOCK (1), the timing-stable flag.
REQ-013 SHALL have output MEAS_TO (1), a sticky timeout flag, cleared when EN goes low.

Function
REQ-014 Line counter SHALL count every cycle and clear on the cycle after HLOCK; line length = count+1 at the HLOCK cycle, saturating at 4095.
REQ-015 Line count SHALL increment per HLOCK; frame VTW = number of HLOCK pulses up to and including the VLOCK cycle.
REQ-016 VLOCK without HLOCK SHALL be treated as HLOCK+VLOCK.
REQ-017 HW SHALL be the ACT-cycle count of the last line in the frame that contained ACT; VW SHALL be the number of lines with at least one ACT cycle.
REQ-018 An ACT cycle coincident with HLOCK or VLOCK SHALL count in the ending line and frame.
REQ-019 For ACT cycles: SUM += DI[9:2], saturating at 0xFFFFFFFF; MIN and MAX SHALL track DI[9:2].
REQ-020 Per-frame accumulators SHALL restart at 0, 0, 255 and 0 respectively (HW, SUM, MIN, MAX).
REQ-021 A frame with no ACT cycles SHALL publish MIN=255, MAX=0, SUM=0, HW=0, VW=0.
REQ-022 FSM states: IDLE, SEEK, MEAS.
REQ-023 FSM transitions: IDLE->SEEK when EN=1; SEEK->MEAS on first VLOCK (partial frame discarded, not published).
REQ-024 FSM transitions: any state->IDLE when EN=0; MEAS->SEEK on timeout.
REQ-025 In MEAS, each VLOCK SHALL load all MEAS_* registers at the next edge, with MEAS_VALID high for that one following cycle.
REQ-026 Lock counter SHALL set to 1 on the first published frame after SEEK.
REQ-027 Lock counter SHALL increment (saturating) when HTW, VTW, HW and VW all equal the previous published values, else reload to 1.
REQ-028 MEAS_LOCK SHALL be 1 while the lock counter is >= LOCK_CNT, updated in the same cycle as MEAS_VALID.
REQ-029 Timeout: TO_CYC consecutive cycles without HLOCK in SEEK/MEAS SHALL set MEAS_TO, clear MEAS_LOCK and the lock counter, and go to SEEK.
REQ-030 EN low SHALL clear all accumulators, the lock counter, MEAS_LOCK and MEAS_TO; MEAS_HTW/VTW/HW/VW/SUM/MIN/MAX SHALL hold their last values.
REQ-031 EN re-assert SHALL go to SEEK (partial frame discarded).

Reset
REQ-032 RSTN low SHALL force IDLE and clear all counters and accumulators.
REQ-033 RSTN low SHALL force MEAS_HTW/VTW/HW/VW/SUM=0, MEAS_MIN=255, MEAS_MAX=0 and MEAS_VALID/LOCK/TO=0.
REQ-034 Reset mid-frame SHALL leave no residue; the first frame after release SHALL be discarded per REQ-023.

Structure
REQ-035 Package sync_meas_pkg SHALL hold the FSM state enum, the width constants (HTW 12, VTW 11, SUM 32, PIX 8) and the MIN/MAX init constants.
REQ-036 Lock counting and comparison SHALL be a sub-module sync_meas_lock; the line/frame accumulators SHALL live in sync_meas.

Verification
REQ-037 Scenario: HTW=20, VTW=10, active cols 2..13, rows 2..7, DI=0x200 -> 2nd VLOCK publishes HTW=20, VTW=10, HW=12, VW=6, SUM=9216, MIN=MAX=128.
REQ-038 Scenario: same timing, LOCK_CNT=3 -> MEAS_LOCK rises with the MEAS_VALID following the 4th VLOCK; a 5th frame with HTW=21 drops it, and it re-locks 2 frames later.
REQ-039 Scenario: HLOCK stopped for 4096 cycles -> MEAS_TO=1 and MEAS_LOCK=0; the next VLOCK is discarded, and publishing resumes at the one after it.
REQ-040 Scenario: EN dropped mid-frame, then re-raised -> outputs hold, LOCK=0, no MEAS_VALID until the 2nd VLOCK after re-enable.
REQ-041 Scenario: DI ramps 0x004..0x3FC over the active area -> MIN=1, MAX=255, SUM equals the model sum; ACT=0 frame -> MIN=255, MAX=0, SUM=0.
REQ-042 Scenario: RSTN pulsed mid-frame -> all outputs at reset values within one cycle; the first post-reset frame is not published.
